// File: rtl/demux16_pkg.sv
// Shared types and sizes for the 16-entry write demultiplexer.
package demux16_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SWEEP = 1'b1
   } state_t;

   localparam int NREG = 16;
   localparam int SELW = 4;

endpackage

// File: rtl/dec4to16.sv
// 4-bit index plus enable to a 16-bit one-hot write strobe.
module dec4to16
   import demux16_pkg::*;
(
   input  logic [SELW-1:0] idx,
   input  logic            en,
   output logic [NREG-1:0] strobe
);

   always_comb begin
      strobe = '0;
      if (en) strobe[idx] = 1'b1;
   end

endmodule

// File: rtl/demux16_wr.sv
// Steers one data word into one of sixteen holding registers; a clear request
// sweeps every entry back to zero, one per cycle.
module demux16_wr
   import demux16_pkg::*;
#(
   parameter int N = 19,
   parameter int J = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [J:0]    opc,
   input  logic [N:0]    din,
   input  logic          clr,
   output logic [N:0]    r0,
   output logic [N:0]    r1,
   output logic [N:0]    r2,
   output logic [N:0]    r3,
   output logic [N:0]    r4,
   output logic [N:0]    r5,
   output logic [N:0]    r6,
   output logic [N:0]    r7,
   output logic [N:0]    r8,
   output logic [N:0]    r9,
   output logic [N:0]    r10,
   output logic [N:0]    r11,
   output logic [N:0]    r12,
   output logic [N:0]    r13,
   output logic [N:0]    r14,
   output logic [N:0]    r15,
   output logic [15:0]   wr_flag,
   output logic          all_written,
   output logic          clr_done
);

   state_t             state;
   logic [SELW-1:0]    idx;
   logic [N:0]         r [NREG];
   logic [SELW-1:0]    dec_idx;
   logic               dec_en;
   logic [NREG-1:0]    strobe;

   // One decoder serves both paths: opc for writes in IDLE, idx for the sweep.
   assign dec_idx  = (state == SWEEP) ? idx : opc;
   assign dec_en   = (state == SWEEP) | in_valid;
   assign in_ready = rst_n & (state == IDLE);

   dec4to16 u_dec (
      .idx    (dec_idx),
      .en     (dec_en),
      .strobe (strobe)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         idx      <= '0;
         clr_done <= 1'b0;
         wr_flag  <= '0;
         for (int unsigned k = 0; k < NREG; k++) r[k] <= '0;
      end else begin
         clr_done <= 1'b0;
         unique case (state)
            IDLE: begin
               for (int unsigned k = 0; k < NREG; k++) begin
                  if (strobe[k]) begin
                     r[k]       <= din;
                     wr_flag[k] <= 1'b1;
                  end
               end
               if (clr) begin
                  state <= SWEEP;
                  idx   <= '0;
               end
            end
            SWEEP: begin
               for (int unsigned k = 0; k < NREG; k++) begin
                  if (strobe[k]) begin
                     r[k]       <= '0;
                     wr_flag[k] <= 1'b0;
                  end
               end
               idx <= idx + 1'b1;
               // Registered pulse lands in the cycle where idx is the last entry.
               clr_done <= (idx == SELW'(NREG - 2));
               if (idx == SELW'(NREG - 1)) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign all_written = &wr_flag;

   assign r0  = r[0];
   assign r1  = r[1];
   assign r2  = r[2];
   assign r3  = r[3];
   assign r4  = r[4];
   assign r5  = r[5];
   assign r6  = r[6];
   assign r7  = r[7];
   assign r8  = r[8];
   assign r9  = r[9];
   assign r10 = r[10];
   assign r11 = r[11];
   assign r12 = r[12];
   assign r13 = r[13];
   assign r14 = r[14];
   assign r15 = r[15];

endmodule

// File: tb/tb_demux16_wr.sv
// Directed bench for demux16_wr: writes, overwrite, clear sweep, write+clear, held write, reset mid-sweep.
module tb_demux16_wr;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  opc;
   logic [19:0] din;
   logic        clr;
   logic [19:0] r0, r1, r2, r3, r4, r5, r6, r7;
   logic [19:0] r8, r9, r10, r11, r12, r13, r14, r15;
   logic [15:0] wr_flag;
   logic        all_written;
   logic        clr_done;
   logic [19:0] rr [16];

   int checks = 0;
   int errors = 0;
   int pulses;

   demux16_wr #(.N(19), .J(3)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .opc(opc), .din(din), .clr(clr),
      .r0(r0), .r1(r1), .r2(r2), .r3(r3), .r4(r4), .r5(r5), .r6(r6), .r7(r7),
      .r8(r8), .r9(r9), .r10(r10), .r11(r11), .r12(r12), .r13(r13), .r14(r14), .r15(r15),
      .wr_flag(wr_flag), .all_written(all_written), .clr_done(clr_done)
   );

   assign rr[0]  = r0;  assign rr[1]  = r1;  assign rr[2]  = r2;  assign rr[3]  = r3;
   assign rr[4]  = r4;  assign rr[5]  = r5;  assign rr[6]  = r6;  assign rr[7]  = r7;
   assign rr[8]  = r8;  assign rr[9]  = r9;  assign rr[10] = r10; assign rr[11] = r11;
   assign rr[12] = r12; assign rr[13] = r13; assign rr[14] = r14; assign rr[15] = r15;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; clr = 1'b0; opc = '0; din = '0;

      // Reset
      #1;
      check_eq("rst_ready_low", 32'(in_ready), 32'h0);
      step(); step();
      for (int k = 0; k < 16; k++) check_eq($sformatf("rst_r%0d", k), 32'(rr[k]), 32'h0);
      check_eq("rst_flag", 32'(wr_flag), 32'h0);
      check_eq("rst_clr_done", 32'(clr_done), 32'h0);
      check_eq("rst_all_written", 32'(all_written), 32'h0);
      rst_n = 1'b1;
      #1;
      check_eq("post_rst_ready", 32'(in_ready), 32'h1);

      // Single write
      opc = 4'd3; din = 20'h0ABCD; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      check_eq("w3_r3", 32'(r3), 32'h0ABCD);
      check_eq("w3_flag", 32'(wr_flag), 32'h0008);
      check_eq("w3_r0", 32'(r0), 32'h0);
      check_eq("w3_r4", 32'(r4), 32'h0);
      check_eq("w3_ready", 32'(in_ready), 32'h1);
      check_eq("w3_all", 32'(all_written), 32'h0);

      // Fill all entries back to back
      for (int k = 0; k < 16; k++) begin
         opc = 4'(k); din = 20'(k * 17); in_valid = 1'b1;
         step();
      end
      in_valid = 1'b0;
      for (int k = 0; k < 16; k++) check_eq($sformatf("fill_r%0d", k), 32'(rr[k]), 32'(k * 17));
      check_eq("fill_flag", 32'(wr_flag), 32'hFFFF);
      check_eq("fill_all", 32'(all_written), 32'h1);

      // Overwrite entry 5
      opc = 4'd5; din = 20'hFFFFF; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      check_eq("ow_r5", 32'(r5), 32'hFFFFF);
      check_eq("ow_flag", 32'(wr_flag), 32'hFFFF);
      check_eq("ow_r6", 32'(r6), 32'h66);

      // Clear sweep
      clr = 1'b1;
      step();
      clr = 1'b0;
      pulses = 0;
      for (int i = 0; i < 16; i++) begin
         check_eq($sformatf("sw_ready_%0d", i), 32'(in_ready), 32'h0);
         check_eq($sformatf("sw_pre_r%0d", i), 32'(rr[i]), (i == 5) ? 32'hFFFFF : 32'(i * 17));
         check_eq($sformatf("sw_pre_flag%0d", i), 32'(wr_flag[i]), 32'h1);
         check_eq($sformatf("sw_done_%0d", i), 32'(clr_done), (i == 15) ? 32'h1 : 32'h0);
         if (clr_done) pulses++;
         step();
         check_eq($sformatf("sw_post_r%0d", i), 32'(rr[i]), 32'h0);
         check_eq($sformatf("sw_post_flag%0d", i), 32'(wr_flag[i]), 32'h0);
      end
      check_eq("sw_pulses", 32'(pulses), 32'h1);
      check_eq("sw_end_ready", 32'(in_ready), 32'h1);
      check_eq("sw_end_done", 32'(clr_done), 32'h0);
      check_eq("sw_end_flag", 32'(wr_flag), 32'h0);

      // Write and clear in the same cycle
      opc = 4'd7; din = 20'h12345; in_valid = 1'b1; clr = 1'b1;
      step();
      in_valid = 1'b0; clr = 1'b0;
      check_eq("wc_r7", 32'(r7), 32'h12345);
      check_eq("wc_flag", 32'(wr_flag), 32'h0080);
      check_eq("wc_ready", 32'(in_ready), 32'h0);
      for (int s = 1; s <= 7; s++) begin
         step();
         check_eq($sformatf("wc_hold_%0d", s), 32'(r7), 32'h12345);
      end
      step();
      check_eq("wc_r7_zero", 32'(r7), 32'h0);
      check_eq("wc_flag_zero", 32'(wr_flag), 32'h0);
      for (int s = 9; s <= 16; s++) step();
      check_eq("wc_end_ready", 32'(in_ready), 32'h1);

      // Write held across a sweep
      clr = 1'b1;
      step();
      clr = 1'b0;
      opc = 4'd2; din = 20'h00055; in_valid = 1'b1;
      for (int s = 1; s <= 16; s++) begin
         step();
         check_eq($sformatf("hold_r2_%0d", s), 32'(r2), 32'h0);
         check_eq($sformatf("hold_flag_%0d", s), 32'(wr_flag), 32'h0);
      end
      check_eq("hold_ready", 32'(in_ready), 32'h1);
      step();
      in_valid = 1'b0;
      check_eq("hold_r2", 32'(r2), 32'h00055);
      check_eq("hold_flag", 32'(wr_flag), 32'h0004);

      // Reset in the middle of a sweep
      opc = 4'd9; din = 20'h99999; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      clr = 1'b1;
      step();
      clr = 1'b0;
      for (int s = 1; s <= 5; s++) step();
      check_eq("mid_r9", 32'(r9), 32'h99999);
      check_eq("mid_flag", 32'(wr_flag), 32'h0200);
      check_eq("mid_done", 32'(clr_done), 32'h0);
      rst_n = 1'b0;
      #1;
      check_eq("mid_rst_ready", 32'(in_ready), 32'h0);
      step();
      check_eq("mid_rst_r9", 32'(r9), 32'h0);
      check_eq("mid_rst_flag", 32'(wr_flag), 32'h0);
      check_eq("mid_rst_done", 32'(clr_done), 32'h0);
      rst_n = 1'b1;
      #1;
      check_eq("mid_rel_ready", 32'(in_ready), 32'h1);
      pulses = 0;
      for (int s = 0; s < 20; s++) begin
         step();
         if (clr_done) pulses++;
      end
      check_eq("mid_no_pulse", 32'(pulses), 32'h0);
      check_eq("mid_final_ready", 32'(in_ready), 32'h1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
